// File: rtl/line_drawer.sv
// Bresenham line rasteriser: accepts one (x0,y0)->(x1,y1) draw command at a time and
// streams in-bounds pixels on an Avalon-ST source, one candidate point per DRAW cycle.
module line_drawer #(
  parameter int         COORD_WIDTH = 11,
  parameter int         COLOR_WIDTH = 8,
  parameter int         WIDTH       = 640,
  parameter int         HEIGHT      = 480,
  parameter logic [7:0] CHANNEL     = 8'd0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [COORD_WIDTH-1:0]               cmd_x0,
  input  logic [COORD_WIDTH-1:0]               cmd_y0,
  input  logic [COORD_WIDTH-1:0]               cmd_x1,
  input  logic [COORD_WIDTH-1:0]               cmd_y1,
  input  logic [COLOR_WIDTH-1:0]               cmd_color,
  output logic                                 st_valid,
  input  logic                                 st_ready,
  output logic [2*COORD_WIDTH+COLOR_WIDTH-1:0] st_data,
  output logic [7:0]                           st_channel,
  output logic                                 busy,
  output logic [1:0]                           dbg_state
);

  localparam int EW = COORD_WIDTH + 2;
  localparam logic [COORD_WIDTH:0]   WIDTH_C  = WIDTH[COORD_WIDTH:0];
  localparam logic [COORD_WIDTH:0]   HEIGHT_C = HEIGHT[COORD_WIDTH:0];
  localparam logic [COORD_WIDTH-1:0] ONE      = 1;

  typedef struct packed {
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [COLOR_WIDTH-1:0] color;
  } pixel_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_DRAW  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [COORD_WIDTH-1:0]  x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COORD_WIDTH-1:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COLOR_WIDTH-1:0]  color_q, color_d;
  logic signed [EW-1:0]    dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                    sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

  logic [COORD_WIDTH-1:0]  adx, ady;
  logic signed [EW-1:0]    setup_dx, setup_dy, e2;
  logic                    in_bounds, at_end, advance;
  pixel_t                  pix;

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
  // waits on ready, and a presented beat holds its data until it is taken.
  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;
  assign st_channel = CHANNEL;

  assign in_bounds = ({1'b0, cur_x_q} < WIDTH_C) && ({1'b0, cur_y_q} < HEIGHT_C);
  assign at_end    = (cur_x_q == x1_q) && (cur_y_q == y1_q);
  assign st_valid  = (state_q == S_DRAW) && in_bounds;
  // Clipped candidates advance without waiting for the sink.
  assign advance   = (state_q == S_DRAW) && (!in_bounds || st_ready);

  assign pix.x     = cur_x_q;
  assign pix.y     = cur_y_q;
  assign pix.color = color_q;
  assign st_data   = pix;

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    color_d  = color_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;

    adx      = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    ady      = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    setup_dx = $signed({2'b00, adx});
    setup_dy = -$signed({2'b00, ady});
    e2       = err_q <<< 1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          x0_d    = cmd_x0;
          y0_d    = cmd_y0;
          x1_d    = cmd_x1;
          y1_d    = cmd_y1;
          color_d = cmd_color;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        dx_d     = setup_dx;
        dy_d     = setup_dy;
        err_d    = setup_dx + setup_dy;
        sx_neg_d = !(x0_q < x1_q);
        sy_neg_d = !(y0_q < y1_q);
        cur_x_d  = x0_q;
        cur_y_d  = y0_q;
        state_d  = S_DRAW;
      end
      S_DRAW: begin
        if (advance) begin
          if (at_end) begin
            state_d = S_IDLE;
          end else begin
            // Both tests use the pre-update error term; err_d accumulates both adds.
            if (e2 >= dy_q) begin
              err_d   = err_d + dy_q;
              cur_x_d = sx_neg_q ? (cur_x_q - ONE) : (cur_x_q + ONE);
            end
            if (e2 <= dx_q) begin
              err_d   = err_d + dx_q;
              cur_y_d = sy_neg_q ? (cur_y_q - ONE) : (cur_y_q + ONE);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      color_q  <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      color_q  <= color_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

endmodule
